// File: rtl/core_types_pkg.sv
`default_nettype none
//==============================================================================
// Package  : core_types_pkg
// Brief    : Shared core types: ALU op encoding and PRF sizing constants.
// Revision : 1.0 - initial release
//==============================================================================
package core_types_pkg;

    localparam int LOG_PR_COUNT       = 6;
    localparam int PRF_BANK_COUNT     = 4;
    localparam int LOG_PRF_BANK_COUNT = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_t;

    // Only SUB and SRA use the top bit; every other 1xxx code aliases its 0xxx op.
    function automatic alu_op_t decode_alu_op(input logic [3:0] raw);
        alu_op_t op;
        if (raw == ALU_SUB || raw == ALU_SRA)
            op = alu_op_t'(raw);
        else
            op = alu_op_t'({1'b0, raw[2:0]});
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_pipeline_if.sv
`default_nettype none
//==============================================================================
// Interface : alu_pipeline_if
// Brief     : Issue, PRF read, forward and writeback signals of the ALU pipe.
// Revision  : 1.0 - initial release
//==============================================================================
interface alu_pipeline_if;
    import core_types_pkg::*;

    logic                                   issue_valid;
    logic [3:0]                             issue_op;
    logic                                   issue_is_imm;
    logic [31:0]                            issue_imm;
    logic                                   issue_A_unneeded;
    logic                                   issue_A_forward;
    logic [LOG_PRF_BANK_COUNT-1:0]          issue_A_bank;
    logic                                   issue_B_forward;
    logic [LOG_PRF_BANK_COUNT-1:0]          issue_B_bank;
    logic [LOG_PR_COUNT-1:0]                issue_dest_PR;
    logic                                   issue_ready;

    logic                                   A_reg_read_ack;
    logic                                   B_reg_read_ack;
    logic [31:0]                            A_reg_read_data;
    logic [31:0]                            B_reg_read_data;
    logic [PRF_BANK_COUNT-1:0][31:0]        forward_data_by_bank;

    logic                                   WB_valid;
    logic [31:0]                            WB_data;
    logic [LOG_PR_COUNT-1:0]                WB_PR;
    logic                                   WB_ready;

    // Issue queue / PRF / arbiter side
    modport master (
        output issue_valid, issue_op, issue_is_imm, issue_imm,
               issue_A_unneeded, issue_A_forward, issue_A_bank,
               issue_B_forward, issue_B_bank, issue_dest_PR,
               A_reg_read_ack, B_reg_read_ack, A_reg_read_data, B_reg_read_data,
               forward_data_by_bank, WB_ready,
        input  issue_ready, WB_valid, WB_data, WB_PR
    );

    // ALU pipeline side
    modport slave (
        input  issue_valid, issue_op, issue_is_imm, issue_imm,
               issue_A_unneeded, issue_A_forward, issue_A_bank,
               issue_B_forward, issue_B_bank, issue_dest_PR,
               A_reg_read_ack, B_reg_read_ack, A_reg_read_data, B_reg_read_data,
               forward_data_by_bank, WB_ready,
        output issue_ready, WB_valid, WB_data, WB_PR
    );

endinterface
`default_nettype wire

// File: rtl/alu_pipeline_alu.sv
`default_nettype none
//==============================================================================
// Module   : alu
// Brief    : Combinational 32-bit integer ALU.
// Revision : 1.0 - initial release
//==============================================================================
module alu
    import core_types_pkg::*;
(
    input  wire alu_op_t     i_op,
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    output logic      [31:0] o_result
);

    logic [4:0] w_shamt;
    assign w_shamt = i_b[4:0];

    // Evaluate the decoded op; shifts only look at the low five bits of B.
    always_comb begin
        o_result = '0;
        case (i_op)
            ALU_ADD:  o_result = i_a + i_b;
            ALU_SUB:  o_result = i_a - i_b;
            ALU_SLL:  o_result = i_a << w_shamt;
            ALU_SLT:  o_result = {31'b0, ($signed(i_a) < $signed(i_b))};
            ALU_SLTU: o_result = {31'b0, (i_a < i_b)};
            ALU_XOR:  o_result = i_a ^ i_b;
            ALU_SRL:  o_result = i_a >> w_shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_a) >>> w_shamt);
            ALU_OR:   o_result = i_a | i_b;
            ALU_AND:  o_result = i_a & i_b;
            default:  o_result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/alu_pipeline.sv
`default_nettype none
//==============================================================================
// Module   : alu_pipeline
// Brief    : Three-stage (operand collect / execute / writeback) ALU pipe fed
//            by the ALU issue queue and drained by the PRF writeback arbiter.
// Revision : 1.0 - initial release
//==============================================================================
module alu_pipeline
    import core_types_pkg::*;
(
    input  wire logic        CLK,
    input  wire logic        nRST,
    alu_pipeline_if.slave    bus
);

    // OC stage
    logic                           r_oc_valid;
    logic                           r_oc_first;
    alu_op_t                        r_oc_op;
    logic [LOG_PR_COUNT-1:0]        r_oc_dest;
    logic                           r_oc_a_fwd;
    logic [LOG_PRF_BANK_COUNT-1:0]  r_oc_a_bank;
    logic                           r_oc_b_fwd;
    logic [LOG_PRF_BANK_COUNT-1:0]  r_oc_b_bank;
    logic                           r_a_done;
    logic [31:0]                    r_a_val;
    logic                           r_b_done;
    logic [31:0]                    r_b_val;
    // EX stage
    logic                           r_ex_valid;
    logic [31:0]                    r_ex_result;
    logic [LOG_PR_COUNT-1:0]        r_ex_dest;
    // WB stage
    logic                           r_wb_valid;
    logic [31:0]                    r_wb_data;
    logic [LOG_PR_COUNT-1:0]        r_wb_pr;

    logic        w_a_capture, w_b_capture, w_a_done, w_b_done;
    logic [31:0] w_a_cap_val, w_b_cap_val, w_a_value, w_b_value, w_result;
    logic        w_ex_advance, w_ex_load, w_oc_advance, w_issue_ready, w_issue_xfer;

    // Merge this cycle's operand arrivals with saved state and derive stage handshakes.
    always_comb begin
        // Forwarded operands are only on the bus during the first OC cycle.
        w_a_cap_val   = r_oc_a_fwd ? bus.forward_data_by_bank[r_oc_a_bank] : bus.A_reg_read_data;
        w_a_capture   = r_oc_valid && !r_a_done && (r_oc_a_fwd ? r_oc_first : bus.A_reg_read_ack);
        w_a_done      = r_a_done || w_a_capture;
        w_a_value     = r_a_done ? r_a_val : w_a_cap_val;

        w_b_cap_val   = r_oc_b_fwd ? bus.forward_data_by_bank[r_oc_b_bank] : bus.B_reg_read_data;
        w_b_capture   = r_oc_valid && !r_b_done && (r_oc_b_fwd ? r_oc_first : bus.B_reg_read_ack);
        w_b_done      = r_b_done || w_b_capture;
        w_b_value     = r_b_done ? r_b_val : w_b_cap_val;

        w_ex_advance  = !r_wb_valid || bus.WB_ready;
        // EX can take a new op when it is empty even if WB is stalled.
        w_ex_load     = !r_ex_valid || w_ex_advance;
        w_oc_advance  = r_oc_valid && w_a_done && w_b_done && w_ex_load;
        w_issue_ready = !r_oc_valid || w_oc_advance;
        w_issue_xfer  = bus.issue_valid && w_issue_ready;
    end

    alu u_alu (
        .i_op     (r_oc_op),
        .i_a      (w_a_value),
        .i_b      (w_b_value),
        .o_result (w_result)
    );

    // OC register: load a new issue, otherwise retire on advance and save captured operands.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_oc_valid  <= 1'b0;
            r_oc_first  <= 1'b0;
            r_oc_op     <= ALU_ADD;
            r_oc_dest   <= '0;
            r_oc_a_fwd  <= 1'b0;
            r_oc_a_bank <= '0;
            r_oc_b_fwd  <= 1'b0;
            r_oc_b_bank <= '0;
            r_a_done    <= 1'b0;
            r_a_val     <= '0;
            r_b_done    <= 1'b0;
            r_b_val     <= '0;
        end else if (w_issue_xfer) begin
            r_oc_valid  <= 1'b1;
            r_oc_first  <= 1'b1;
            r_oc_op     <= decode_alu_op(bus.issue_op);
            r_oc_dest   <= bus.issue_dest_PR;
            r_oc_a_fwd  <= bus.issue_A_forward;
            r_oc_a_bank <= bus.issue_A_bank;
            r_oc_b_fwd  <= bus.issue_B_forward;
            r_oc_b_bank <= bus.issue_B_bank;
            r_a_done    <= bus.issue_A_unneeded;
            r_a_val     <= '0;
            r_b_done    <= bus.issue_is_imm;
            r_b_val     <= bus.issue_imm;
        end else begin
            r_oc_first <= 1'b0;
            if (w_oc_advance)
                r_oc_valid <= 1'b0;
            if (w_a_capture) begin
                r_a_done <= 1'b1;
                r_a_val  <= w_a_cap_val;
            end
            if (w_b_capture) begin
                r_b_done <= 1'b1;
                r_b_val  <= w_b_cap_val;
            end
        end
    end

    // EX register: capture the ALU result on the OC advance edge.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_ex_valid  <= 1'b0;
            r_ex_result <= '0;
            r_ex_dest   <= '0;
        end else if (w_ex_load) begin
            r_ex_valid <= w_oc_advance;
            if (w_oc_advance) begin
                r_ex_result <= w_result;
                r_ex_dest   <= r_oc_dest;
            end
        end
    end

    // WB register: hold while stalled, otherwise replace with EX contents or clear.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wb_valid <= 1'b0;
            r_wb_data  <= '0;
            r_wb_pr    <= '0;
        end else if (w_ex_advance) begin
            r_wb_valid <= r_ex_valid;
            r_wb_data  <= r_ex_valid ? r_ex_result : 32'h0;
            r_wb_pr    <= r_ex_valid ? r_ex_dest   : '0;
        end
    end

    assign bus.issue_ready = w_issue_ready;
    assign bus.WB_valid    = r_wb_valid;
    assign bus.WB_data     = r_wb_data;
    assign bus.WB_PR       = r_wb_pr;

endmodule
`default_nettype wire

// File: tb/tb_alu_pipeline.sv
`default_nettype none
//==============================================================================
// Module   : tb_alu_pipeline
// Brief    : Self-checking bench for alu_pipeline: directed cases with literal
//            expectations followed by randomized traffic against an in-order
//            result queue model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_alu_pipeline;
    import core_types_pkg::*;

    logic CLK  = 1'b0;
    logic nRST = 1'b0;
    always #5 CLK = ~CLK;

    alu_pipeline_if bus ();

    alu_pipeline dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] data;
        logic [5:0]  pr;
    } wb_t;
    wb_t exp_q[$];

    // Operand sources: 0 = unneeded/immediate, 1 = forward bus, 2 = PRF read
    typedef struct {
        logic [3:0]  op;
        int          a_src, b_src;
        logic [1:0]  a_bank, b_bank;
        logic [31:0] a_val, b_val;
        int          a_dly, b_dly;
        logic [5:0]  dest;
    } op_t;

    op_t         cur, nxt;
    bit          have_cur = 0, xfer = 0, leave = 0, prev_hold = 0;
    int          cur_age = 0;
    logic [31:0] prev_data;
    logic [5:0]  prev_pr;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Result an op must produce, from the instruction-set definition.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (op[2:0])
            3'd0: r = op[3] ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
                r = a >> sh;
                if (op[3] && a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        bus.issue_valid          = 1'b0;
        bus.issue_op             = 4'h0;
        bus.issue_is_imm         = 1'b0;
        bus.issue_imm            = 32'h0;
        bus.issue_A_unneeded     = 1'b0;
        bus.issue_A_forward      = 1'b0;
        bus.issue_A_bank         = 2'd0;
        bus.issue_B_forward      = 1'b0;
        bus.issue_B_bank         = 2'd0;
        bus.issue_dest_PR        = 6'h0;
        bus.A_reg_read_ack       = 1'b0;
        bus.B_reg_read_ack       = 1'b0;
        bus.A_reg_read_data      = 32'h0;
        bus.B_reg_read_data      = 32'h0;
        bus.forward_data_by_bank = '0;
        bus.WB_ready             = 1'b1;
    endtask

    task automatic set_issue(input logic [3:0] op, input logic is_imm, input logic [31:0] imm,
                             input logic a_un, input logic a_fwd, input logic [1:0] a_bank,
                             input logic b_fwd, input logic [1:0] b_bank, input logic [5:0] dest);
        bus.issue_valid      = 1'b1;
        bus.issue_op         = op;
        bus.issue_is_imm     = is_imm;
        bus.issue_imm        = imm;
        bus.issue_A_unneeded = a_un;
        bus.issue_A_forward  = a_fwd;
        bus.issue_A_bank     = a_bank;
        bus.issue_B_forward  = b_fwd;
        bus.issue_B_bank     = b_bank;
        bus.issue_dest_PR    = dest;
    endtask

    task automatic rand_fwd();
        for (int k = 0; k < 4; k++) bus.forward_data_by_bank[k] = $urandom;
    endtask

    // Single op: A forwarded on bank 1 in its first OC cycle, B immediate.
    task automatic alu_one(input string name, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp);
        cyc(); set_issue(op, 1'b1, b, 1'b0, 1'b1, 2'd1, 1'b0, 2'd0, 6'h2A);
        cyc(); bus.issue_valid = 1'b0; rand_fwd(); bus.forward_data_by_bank[1] = a;
        cyc(); rand_fwd();
        cyc(); settle();
        chk({name, "_data"}, bus.WB_data, exp);
        chk({name, "_pr"}, {26'b0, bus.WB_PR}, 32'h2A);
    endtask

    // Drive one acknowledgement channel for the op the bench believes is in OC.
    task automatic drive_ack(input int src, input int dly, input logic [31:0] val,
                             output logic ack, output logic [31:0] data);
        bit due, done_already;
        due          = have_cur && src == 2 && cur_age == dly;
        done_already = !have_cur || src == 0 || (src == 2 && cur_age > dly) ||
                       (src == 1 && cur_age > 0);
        data = $urandom;
        ack  = 1'b0;
        if (due) begin
            ack  = 1'b1;
            data = val;
        end else if (done_already && $urandom_range(0, 3) == 0) begin
            ack = 1'b1;
        end
    endtask

    task automatic rand_cycle(input bit allow_issue);
        logic        ack;
        logic [31:0] data;
        wb_t         e;
        cyc();
        if (leave) have_cur = 0;
        if (xfer) begin
            cur      = nxt;
            have_cur = 1;
            cur_age  = 0;
        end else if (have_cur) begin
            cur_age++;
        end

        bus.WB_ready = allow_issue ? ($urandom_range(0, 3) != 0) : 1'b1;
        rand_fwd();
        if (have_cur && cur_age == 0) begin
            if (cur.a_src == 1) bus.forward_data_by_bank[cur.a_bank] = cur.a_val;
            if (cur.b_src == 1) bus.forward_data_by_bank[cur.b_bank] = cur.b_val;
        end
        drive_ack(cur.a_src, cur.a_dly, cur.a_val, ack, data);
        bus.A_reg_read_ack = ack; bus.A_reg_read_data = data;
        drive_ack(cur.b_src, cur.b_dly, cur.b_val, ack, data);
        bus.B_reg_read_ack = ack; bus.B_reg_read_data = data;

        if (allow_issue && $urandom_range(0, 9) < 7) begin
            nxt.op     = 4'($urandom);
            nxt.a_src  = $urandom_range(0, 2);
            nxt.b_src  = $urandom_range(0, 2);
            nxt.a_bank = 2'($urandom);
            nxt.b_bank = 2'($urandom);
            nxt.a_val  = (nxt.a_src == 0) ? 32'h0 : $urandom;
            nxt.b_val  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if (nxt.a_src == 1 && nxt.b_src == 1 && nxt.a_bank == nxt.b_bank)
                nxt.b_val = nxt.a_val;
            nxt.a_dly  = $urandom_range(0, 3);
            nxt.b_dly  = $urandom_range(0, 3);
            nxt.dest   = 6'($urandom);
            set_issue(nxt.op, nxt.b_src == 0, (nxt.b_src == 0) ? nxt.b_val : $urandom,
                      nxt.a_src == 0, nxt.a_src == 1, nxt.a_bank,
                      nxt.b_src == 1, nxt.b_bank, nxt.dest);
        end else begin
            bus.issue_valid = 1'b0;
        end

        settle();
        xfer  = bus.issue_valid && bus.issue_ready;
        leave = have_cur && bus.issue_ready;
        if (xfer) begin
            e.data = ref_alu(nxt.op, nxt.a_val, nxt.b_val);
            e.pr   = nxt.dest;
            exp_q.push_back(e);
        end

        if (bus.WB_valid) begin
            if (prev_hold) begin
                chk("hold_data", bus.WB_data, prev_data);
                chk("hold_pr", {26'b0, bus.WB_PR}, {26'b0, prev_pr});
            end
            if (bus.WB_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_wb actual=%h@%h required=none", bus.WB_data, bus.WB_PR);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_data", bus.WB_data, e.data);
                    chk("rand_pr", {26'b0, bus.WB_PR}, {26'b0, e.pr});
                end
            end
        end
        prev_hold = bus.WB_valid && !bus.WB_ready;
        prev_data = bus.WB_data;
        prev_pr   = bus.WB_PR;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle();
        // Reset
        nRST = 1'b0;
        cyc(); cyc(); settle();
        chk("rst_wb_valid", {31'b0, bus.WB_valid}, 32'h0);
        chk("rst_wb_data", bus.WB_data, 32'h0);
        chk("rst_wb_pr", {26'b0, bus.WB_PR}, 32'h0);
        chk("rst_issue_ready", {31'b0, bus.issue_ready}, 32'h1);
        nRST = 1'b1;

        // Back-to-back immediates
        cyc(); set_issue(4'b0000, 1'b1, 32'd5, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 6'h11);
        settle(); chk("b2b_ready0", {31'b0, bus.issue_ready}, 32'h1);
        cyc(); set_issue(4'b1000, 1'b1, 32'd3, 1'b0, 1'b1, 2'd2, 1'b0, 2'd0, 6'h12);
        settle(); chk("b2b_ready1", {31'b0, bus.issue_ready}, 32'h1);
        cyc(); bus.issue_valid = 1'b0; rand_fwd(); bus.forward_data_by_bank[2] = 32'd10;
        cyc(); rand_fwd(); settle();
        chk("b2b_v1", {31'b0, bus.WB_valid}, 32'h1);
        chk("b2b_d1", bus.WB_data, 32'd5);
        chk("b2b_p1", {26'b0, bus.WB_PR}, 32'h11);
        cyc(); settle();
        chk("b2b_d2", bus.WB_data, 32'd7);
        chk("b2b_p2", {26'b0, bus.WB_PR}, 32'h12);
        cyc(); settle();
        chk("b2b_empty", {31'b0, bus.WB_valid}, 32'h0);

        // Delayed PRF operands; a stray ack while OC is empty and one after A is done
        cyc(); idle(); set_issue(4'b0100, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 2'd0, 1'b0, 2'd0, 6'h20);
        bus.A_reg_read_ack = 1'b1; bus.A_reg_read_data = 32'h5555_5555;
        cyc(); bus.issue_valid = 1'b0; bus.A_reg_read_data = 32'h0000_FF00;
        settle(); chk("dly_ready_oc1", {31'b0, bus.issue_ready}, 32'h0);
        cyc(); bus.A_reg_read_data = 32'h1234_5678;
        settle(); chk("dly_ready_oc2", {31'b0, bus.issue_ready}, 32'h0);
        cyc(); bus.A_reg_read_ack = 1'b0; bus.B_reg_read_ack = 1'b1; bus.B_reg_read_data = 32'h0000_0FF0;
        settle(); chk("dly_ready_oc3", {31'b0, bus.issue_ready}, 32'h1);
        cyc(); bus.B_reg_read_ack = 1'b0; settle();
        chk("dly_wb_early", {31'b0, bus.WB_valid}, 32'h0);
        cyc(); settle();
        chk("dly_wb_valid", {31'b0, bus.WB_valid}, 32'h1);
        chk("dly_wb_data", bus.WB_data, 32'h0000_F0F0);
        chk("dly_wb_pr", {26'b0, bus.WB_PR}, 32'h20);

        // Backpressure with three ops in flight
        cyc(); idle(); bus.WB_ready = 1'b0;
        set_issue(4'b0000, 1'b1, 32'd100, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 6'h01);
        cyc(); bus.issue_imm = 32'd200; bus.issue_dest_PR = 6'h02;
        cyc(); bus.issue_imm = 32'd300; bus.issue_dest_PR = 6'h03;
        for (int i = 0; i < 3; i++) begin
            cyc(); bus.issue_valid = 1'b0; settle();
            chk("bp_hold_valid", {31'b0, bus.WB_valid}, 32'h1);
            chk("bp_hold_data", bus.WB_data, 32'd100);
            chk("bp_issue_ready", {31'b0, bus.issue_ready}, 32'h0);
        end
        cyc(); bus.WB_ready = 1'b1; settle();
        chk("bp_drain1", bus.WB_data, 32'd100);
        cyc(); settle();
        chk("bp_drain2", bus.WB_data, 32'd200);
        chk("bp_drain2_pr", {26'b0, bus.WB_PR}, 32'h02);
        cyc(); settle();
        chk("bp_drain3", bus.WB_data, 32'd300);
        cyc(); settle();
        chk("bp_empty", {31'b0, bus.WB_valid}, 32'h0);

        // Signed/unsigned compare, arithmetic shift and aliased codes
        alu_one("slt", 4'b0010, 32'hFFFF_FFFF, 32'd1, 32'h1);
        alu_one("sltu", 4'b0011, 32'hFFFF_FFFF, 32'd1, 32'h0);
        alu_one("sra", 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000);
        alu_one("op1010", 4'b1010, 32'hFFFF_FFFF, 32'd1, 32'h1);
        alu_one("srl", 4'b0101, 32'h8000_0000, 32'd36, 32'h0800_0000);
        alu_one("sub_wrap", 4'b1000, 32'h0, 32'd1, 32'hFFFF_FFFF);

        // Reset with OC and EX occupied
        cyc(); idle(); set_issue(4'b0000, 1'b1, 32'd77, 1'b1, 1'b0, 2'd0, 1'b0, 2'd0, 6'h05);
        cyc(); bus.issue_imm = 32'd88; bus.issue_dest_PR = 6'h06;
        cyc(); bus.issue_valid = 1'b0; nRST = 1'b0;
        cyc(); nRST = 1'b1; settle();
        chk("mr_wb_valid", {31'b0, bus.WB_valid}, 32'h0);
        chk("mr_issue_ready", {31'b0, bus.issue_ready}, 32'h1);
        for (int i = 0; i < 4; i++) begin
            cyc(); settle();
            chk("mr_no_stale", {31'b0, bus.WB_valid}, 32'h0);
        end

        // Randomized traffic
        idle();
        nRST = 1'b0;
        cyc(); cyc();
        nRST = 1'b1;
        exp_q.delete();
        for (int i = 0; i < 3000; i++) rand_cycle(1'b1);
        for (int i = 0; i < 200; i++) begin
            rand_cycle(1'b0);
            if (exp_q.size() == 0 && !have_cur) break;
        end
        chk("drain_queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
